// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - shared encodings and defaults for the execute-stage ALU and mult/div engine
package alu_md_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_AND  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_SRL  = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_core.sv
// rtl/md_core.sv - multi-cycle multiply/divide engine owning HI/LO
// Result is formed from latched operands and committed on the edge where the counter is 1.
module md_core
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  md_state_t          r_state;
  md_state_t          w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  md_op_t             r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_commit;
  logic               w_mt_hi;
  logic               w_mt_lo;
  logic [2*WIDTH-1:0] w_result;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_is_mul     = 1'b0;
    w_commit     = 1'b0;
    w_mt_hi      = 1'b0;
    w_mt_lo      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md_start && !md_cancel) begin
          case (md_op_t'(md_op))
            MD_MULT, MD_MULTU: begin
              w_accept     = 1'b1;
              w_is_mul     = 1'b1;
              w_next_state = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              w_accept     = 1'b1;
              w_next_state = ST_RUN;
            end
            MD_MTHI: w_mt_hi = 1'b1;
            MD_MTLO: w_mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A flush on the commit edge still wins: nothing is written.
        if (md_cancel) begin
          w_next_state = ST_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_mag_q;
  logic [WIDTH-1:0]   w_mag_r;
  logic [WIDTH-1:0]   w_s_quo;
  logic [WIDTH-1:0]   w_s_rem;
  logic               w_b_zero;
  logic               w_s_ovf;

  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Signed divide runs on magnitudes; quotient and remainder signs are restored afterwards.
  assign w_a_neg  = r_a[WIDTH-1];
  assign w_b_neg  = r_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (-r_a) : r_a;
  assign w_b_mag  = w_b_neg ? (-r_b) : r_b;
  assign w_b_zero = (r_b == '0);
  assign w_mag_q  = w_b_zero ? '0 : (w_a_mag / w_b_mag);
  assign w_mag_r  = w_b_zero ? '0 : (w_a_mag % w_b_mag);
  assign w_s_quo  = (w_a_neg ^ w_b_neg) ? (-w_mag_q) : w_mag_q;
  assign w_s_rem  = w_a_neg ? (-w_mag_r) : w_mag_r;
  assign w_s_ovf  = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);

  always_comb begin
    w_result = {r_hi, r_lo};
    case (r_op)
      MD_MULT:  w_result = w_prod_s;
      MD_MULTU: w_result = w_prod_u;
      MD_DIV: begin
        if (w_b_zero)     w_result = {r_a, {WIDTH{1'b1}}};
        else if (w_s_ovf) w_result = {{WIDTH{1'b0}}, r_a};
        else              w_result = {w_s_rem, w_s_quo};
      end
      MD_DIVU: begin
        if (w_b_zero) w_result = {r_a, {WIDTH{1'b1}}};
        else          w_result = {r_a % r_b, r_a / r_b};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= MD_NONE;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= md_op_t'(md_op);
        r_cnt <= w_is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
      end else if (r_state == ST_RUN) begin
        r_cnt <= md_cancel ? '0 : (r_cnt - CW'(1));
      end
      if (w_commit) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
      if (w_mt_hi) r_hi <= a;
      if (w_mt_lo) r_lo <= a;
    end
  end

  assign md_busy = (r_state == ST_RUN);
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - execute-stage unit: combinational integer ALU plus mult/div engine
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] c,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_sra;

  // Shift amount comes from A; the value being shifted is B.
  assign w_shamt = a[SHW-1:0];
  assign w_slt   = ($signed(a) < $signed(b));
  assign w_sltu  = (a < b);
  assign w_sra   = $unsigned($signed(b) >>> w_shamt);

  always_comb begin
    c = '0;
    case (alu_op_t'(alu_op))
      ALU_ADD:  c = a + b;
      ALU_SUB:  c = a - b;
      ALU_OR:   c = a | b;
      ALU_SLL:  c = b << w_shamt;
      ALU_SLT:  c = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU: c = {{(WIDTH-1){1'b0}}, w_sltu};
      ALU_AND:  c = a & b;
      ALU_NOR:  c = ~(a | b);
      ALU_XOR:  c = a ^ b;
      ALU_SRA:  c = w_sra;
      ALU_SRL:  c = b >> w_shamt;
      default:  c = '0;
    endcase
  end

  md_core #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .md_op     (md_op),
    .md_start  (md_start),
    .md_cancel (md_cancel),
    .md_busy   (md_busy),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed self-checking bench for alu_md (32-bit default and 16-bit/1-cycle multiply)
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0, c;
  logic [3:0]  alu_op = '0;
  logic [2:0]  md_op = '0;
  logic        md_start = 1'b0, md_cancel = 1'b0, md_busy;
  logic [31:0] hi, lo;

  logic [15:0] a16 = '0, b16 = '0, c16, hi16, lo16;
  logic [3:0]  alu_op16 = '0;
  logic [2:0]  md_op16 = '0;
  logic        md_start16 = 1'b0, md_cancel16 = 1'b0, md_busy16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_md u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_op(alu_op), .c(c),
    .md_op(md_op), .md_start(md_start), .md_cancel(md_cancel),
    .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  alu_md #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(10)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .alu_op(alu_op16), .c(c16),
    .md_op(md_op16), .md_start(md_start16), .md_cancel(md_cancel16),
    .md_busy(md_busy16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    md_op = op; a = va; b = vb; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0;
  endtask

  // Counts busy cycles from the current negedge; stops at the first idle cycle or the budget.
  task automatic count_busy(output int n);
    n = 0;
    while (md_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(op, va, vb);
    count_busy(n);
    chk({name, "_busy"}, n, lat);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;

    vecs.push_back('{"add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{"sub_wrap", 4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
    vecs.push_back('{"or",       4'd2,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF});
    vecs.push_back('{"sll",      4'd3,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010});
    vecs.push_back('{"sll_hi_a", 4'd3,  32'h0000_0024, 32'h0000_0003, 32'h0000_0030});
    vecs.push_back('{"slt",      4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001});
    vecs.push_back('{"sltu",     4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
    vecs.push_back('{"and",      4'd6,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00});
    vecs.push_back('{"nor",      4'd7,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F});
    vecs.push_back('{"xor",      4'd8,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555});
    vecs.push_back('{"sra_neg",  4'd9,  32'h0000_0005, 32'hF000_0000, 32'hFF80_0000});
    vecs.push_back('{"sra_pos",  4'd9,  32'h0000_0004, 32'h7000_0000, 32'h0700_0000});
    vecs.push_back('{"srl",      4'd10, 32'h0000_0005, 32'hF000_0000, 32'h0780_0000});
    vecs.push_back('{"op11",     4'd11, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
    vecs.push_back('{"op15",     4'd15, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});

    #2;
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      alu_op = vecs[i].op; a = vecs[i].va; b = vecs[i].vb;
      #1;
      chk(vecs[i].name, c, vecs[i].exp);
    end
    alu_op16 = 4'd9; a16 = 16'd4; b16 = 16'h8000;
    #1;
    chk("sra16", {16'd0, c16}, 32'h0000_F800);

    run_md("mult",   3'd1, 32'hFFFF_FFFD, 32'd7,        5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("multu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("div",    3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_nd", 3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md("div_ov", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_md("divu",   3'd4, 32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E);
    run_md("divu_z", 3'd4, 32'd9,         32'd0,        10, 32'h0000_0009, 32'hFFFF_FFFF);
    run_md("div_z",  3'd3, 32'hFFFF_FFF0, 32'd0,        10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // MTHI/MTLO take effect one cycle after issue without raising busy.
    issue(3'd5, 32'h0000_1234, 32'd0);
    chk("mthi_busy", {31'd0, md_busy}, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    issue(3'd6, 32'h0000_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_5678);

    // Cancel on the 10th (commit) busy cycle of a DIV.
    issue(3'd3, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    chk("cancel_pre_busy", {31'd0, md_busy}, 32'd1);
    md_cancel = 1'b1;
    @(negedge clk);
    md_cancel = 1'b0;
    chk("cancel_busy", {31'd0, md_busy}, 32'd0);
    chk("cancel_hi", hi, 32'h0000_1234);
    chk("cancel_lo", lo, 32'h0000_5678);
    @(negedge clk);
    chk("cancel_after_hi", hi, 32'h0000_1234);

    // Start plus cancel while idle: no busy, and MTHI is suppressed too.
    md_cancel = 1'b1;
    issue(3'd1, 32'd3, 32'd3);
    chk("idle_cancel_busy", {31'd0, md_busy}, 32'd0);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    md_cancel = 1'b0;
    chk("idle_cancel_mthi", hi, 32'h0000_1234);

    // A start while busy is ignored and live operand changes do not matter.
    issue(3'd1, 32'd6, 32'd7);
    md_op = 3'd2; a = 32'd100; b = 32'd100; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0; a = 32'hFFFF_0000; b = 32'h1234_5678;
    count_busy(n);
    chk("ignore_busy_rest", n, 32'd4);
    chk("ignore_hi", hi, 32'd0);
    chk("ignore_lo", lo, 32'd42);
    @(negedge clk);
    chk("ignore_no_restart", {31'd0, md_busy}, 32'd0);

    // Asynchronous reset in the 3rd busy cycle.
    issue(3'd5, 32'h0000_ABCD, 32'd0);
    issue(3'd1, 32'd5, 32'd5);
    repeat (2) @(negedge clk);
    chk("rst_mid_pre", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_stays", lo, 32'd0);

    // 16-bit instance with a single-cycle multiply.
    @(negedge clk);
    md_op16 = 3'd1; a16 = 16'hFED4; b16 = 16'd200; md_start16 = 1'b1;
    @(negedge clk);
    md_start16 = 1'b0; md_op16 = 3'd0;
    chk("m16_busy1", {31'd0, md_busy16}, 32'd1);
    @(negedge clk);
    chk("m16_busy2", {31'd0, md_busy16}, 32'd0);
    chk("m16_prod", {hi16, lo16}, 32'hFFFF_15A0);
    md_op16 = 3'd2; a16 = 16'hFFFF; b16 = 16'hFFFF; md_start16 = 1'b1;
    @(negedge clk);
    md_start16 = 1'b0; md_op16 = 3'd0;
    @(negedge clk);
    chk("m16u_busy", {31'd0, md_busy16}, 32'd0);
    chk("m16u_prod", {hi16, lo16}, 32'hFFFE_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
